// File: rtl/video_in_pkg.sv
`default_nettype none
//==============================================================================
// Module      : video_in_pkg
// Description : Shared definitions for the video input path: default data
//               width and burst length, capture-controller state encoding and
//               the Wishbone burst tag constants.
// Revision    : 1.0 - initial release
//==============================================================================
package video_in_pkg;

   localparam int DATA_SIZE = 32;   // FIFO / Wishbone data width
   localparam int BURST_LEN = 16;   // beats per Wishbone burst (power of two)

   // Wishbone registered-feedback cycle type identifiers
   localparam logic [2:0] CTI_INCR   = 3'b010;  // incrementing burst beat
   localparam logic [2:0] CTI_END    = 3'b111;  // final beat of a burst
   localparam logic [1:0] BTE_LINEAR = 2'b00;   // linear (non-wrapping) burst

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      WAIT  = 3'd2,
      BURST = 3'd3,
      DONE  = 3'd4
   } vin_state_e;

endpackage
`default_nettype wire

// File: rtl/video_in_burst_ctrl.sv
`default_nettype none
//==============================================================================
// Module      : video_in_burst_ctrl
// Description : Moves captured video words from the line FIFO into a frame
//               buffer through Wishbone incrementing write bursts. A frame
//               begins at frame_start (base address latched), and each burst
//               of BURST_LEN words is launched once the FIFO holds that many.
// Ports       : clk, nRST           - clock, async active-low reset
//               enable, frame_start - capture enable level, frame sync pulse
//               frame_base          - frame buffer byte address
//               fifo_*              - FIFO head word, burst-ready flag, pop
//               wb_*                - Wishbone master burst interface
//               frame_done/miss     - one-cycle status pulses
// Revision    : 1.0 - initial release
//==============================================================================
module video_in_burst_ctrl #(
   parameter int DATA_SIZE   = video_in_pkg::DATA_SIZE,
   parameter int BURST_LEN   = video_in_pkg::BURST_LEN,
   parameter int FRAME_WORDS = 76800
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic                 enable,
   input  logic                 frame_start,
   input  logic [31:0]          frame_base,
   input  logic [DATA_SIZE-1:0] fifo_data,
   input  logic                 fifo_burst_ready,
   output logic                 fifo_r_ack,
   output logic                 wb_cyc_o,
   output logic                 wb_stb_o,
   output logic                 wb_we_o,
   output logic [31:0]          wb_adr_o,
   output logic [DATA_SIZE-1:0] wb_dat_o,
   output logic [3:0]           wb_sel_o,
   output logic [2:0]           wb_cti_o,
   output logic [1:0]           wb_bte_o,
   input  logic                 wb_ack_i,
   output logic                 frame_done,
   output logic                 frame_miss
);
   import video_in_pkg::*;

   localparam int WCW = $clog2(FRAME_WORDS + 1);
   localparam int BCW = $clog2(BURST_LEN);
   localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

   vin_state_e     state_q, state_d;
   logic [WCW-1:0] word_cnt_q, word_cnt_d;
   logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
   logic [31:0]    base_lat_q, base_lat_d;
   logic           cyc_q;
   logic           miss_q, miss_d;
   logic           in_burst;
   logic           last_beat;

   assign in_burst  = (state_q == BURST);
   assign last_beat = (beat_cnt_q == LAST_BEAT);

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         word_cnt_q <= '0;
         beat_cnt_q <= '0;
         base_lat_q <= '0;
         cyc_q      <= 1'b0;
         miss_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         beat_cnt_q <= beat_cnt_d;
         base_lat_q <= base_lat_d;
         // cyc/stb come from a flop so the bus sees a glitch-free strobe
         // that rises the cycle after the FSM commits to a burst.
         cyc_q      <= (state_d == BURST);
         miss_q     <= miss_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      beat_cnt_d = beat_cnt_q;
      base_lat_d = base_lat_q;
      // A sync pulse arriving while a frame is in flight is dropped and flagged.
      miss_d     = frame_start &&
                   ((state_q == WAIT) || (state_q == BURST) || (state_q == DONE));

      case (state_q)
         IDLE: begin
            if (enable) state_d = SYNC;
         end
         SYNC: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (frame_start) begin
               base_lat_d = frame_base;
               word_cnt_d = '0;
               beat_cnt_d = '0;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (!enable)               state_d = IDLE;
            else if (fifo_burst_ready) state_d = BURST;
         end
         BURST: begin
            // enable is only looked at on the last beat: an open bus cycle is
            // always completed.
            if (wb_ack_i) begin
               word_cnt_d = word_cnt_q + WCW'(1);
               beat_cnt_d = beat_cnt_q + BCW'(1);
               if (last_beat) begin
                  if (word_cnt_q == LAST_WORD) state_d = DONE;
                  else if (enable)             state_d = WAIT;
                  else                         state_d = IDLE;
               end
            end
         end
         DONE: begin
            state_d = enable ? SYNC : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wb_cyc_o   = cyc_q;
   assign wb_stb_o   = cyc_q;
   assign wb_we_o    = cyc_q;
   assign wb_sel_o   = cyc_q ? 4'hF : 4'h0;
   assign wb_bte_o   = BTE_LINEAR;
   assign wb_cti_o   = !cyc_q   ? 3'b000  :
                       last_beat ? CTI_END : CTI_INCR;
   // Word-to-byte address; any carry past bit 31 is discarded.
   assign wb_adr_o   = base_lat_q + (32'(word_cnt_q) << 2);
   assign wb_dat_o   = fifo_data;
   assign fifo_r_ack = in_burst & wb_ack_i;
   assign frame_done = (state_q == DONE);
   assign frame_miss = miss_q;

endmodule
`default_nettype wire

// File: doc/video_in_burst_ctrl.md
VIDEO_IN_BURST_CTRL -- requirements
Module: video_in_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32: FIFO and Wishbone data width.
REQ-002 SHALL have parameter BURST_LEN, default 16: beats per Wishbone burst; power of two.
REQ-003 SHALL have parameter FRAME_WORDS, default 76800: words per frame; a multiple of BURST_LEN.
REQ-004 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-005 SHALL have port nRST, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1: capture enable, level.
REQ-007 SHALL have port frame_start, input, 1: one-cycle pulse at the video frame sync.
REQ-008 SHALL have port frame_base, input, 32: frame buffer byte address, sampled at frame start.
REQ-009 SHALL have port fifo_data, input, DATA_SIZE: FIFO head word.
REQ-010 SHALL have port fifo_burst_ready, input, 1: FIFO holds at least BURST_LEN words.
REQ-011 SHALL have port fifo_r_ack, output, 1: pops the FIFO head.
REQ-012 SHALL have ports wb_cyc_o, wb_stb_o and wb_we_o, each output, 1: Wishbone master controls.
REQ-013 SHALL have ports wb_adr_o, output, 32, and wb_dat_o, output, DATA_SIZE: Wishbone address and write data.
REQ-014 SHALL have ports wb_sel_o, output, 4; wb_cti_o, output, 3; and wb_bte_o, output, 2: Wishbone byte select and burst tags.
REQ-015 SHALL have port wb_ack_i, input, 1: slave acknowledge.
REQ-016 SHALL have ports frame_done and frame_miss, each output, 1: one-cycle status pulses.

Function
REQ-017 SHALL use FSM states IDLE, SYNC, WAIT, BURST and DONE.
REQ-018 SHALL move from IDLE to SYNC when enable=1.
REQ-019 SHALL, in SYNC with frame_start=1, latch frame_base, clear word_cnt and move to WAIT.
REQ-020 SHALL move from WAIT to BURST on fifo_burst_ready=1; cyc and stb are registered and go high on the next cycle.
REQ-021 SHALL, in BURST, hold cyc, stb and we at 1, sel at 4'hF and bte at 2'b00, with dat_o driven from fifo_data.
REQ-022 SHALL drive adr_o = base_lat + 4*word_cnt.
REQ-023 SHALL keep fifo_r_ack = (state==BURST) & wb_ack_i, so there is exactly one pop per acked beat.
REQ-024 SHALL increment word_cnt and beat_cnt on each ack, and leave addr and data stable while ack=0.
REQ-025 SHALL drive cti=3'b010 on every beat except the last (beat_cnt==BURST_LEN-1), which uses 3'b111.
REQ-026 SHALL end the burst on the last ack, dropping cyc and stb in the following cycle with no idle cycle inside a burst.
REQ-027 SHALL, after a burst with word_cnt==FRAME_WORDS, go to DONE, pulse frame_done for one cycle and return to SYNC (or IDLE if enable=0).
REQ-028 SHALL otherwise, after a burst, return to WAIT (or IDLE if enable=0).
REQ-029 SHALL ignore frame_start in WAIT, BURST or DONE and pulse frame_miss for one cycle instead.
REQ-030 SHALL, when enable falls mid-burst, complete the burst before going to IDLE, so a cycle is never aborted.
REQ-031 SHALL go to IDLE when enable falls in SYNC or WAIT.
REQ-032 SHALL size word_cnt as $clog2(FRAME_WORDS+1) bits and beat_cnt as $clog2(BURST_LEN) bits, with no wrap inside a frame.
REQ-033 SHALL compute the address in 32 bits, dropping any carry out of bit 31.
REQ-034 SHALL never assert fifo_r_ack outside BURST.
REQ-035 SHALL drive wb_stb_o equal to wb_cyc_o at all times.

Reset
REQ-036 SHALL set state IDLE and clear word_cnt, beat_cnt and base_lat while nRST=0.
REQ-037 SHALL hold cyc, stb, we, fifo_r_ack, frame_done and frame_miss at 0 while nRST=0.
REQ-038 SHALL hold adr_o at 0, cti and bte at 0 and sel at 0 while nRST=0.
REQ-039 SHALL, on reset assertion mid-burst, drop cyc and stb asynchronously, with no further FIFO pop.

Structure
REQ-040 SHALL take DATA_SIZE, BURST_LEN, the state enum and the CTI constants (CTI_INCR, CTI_END) from shared package video_in_pkg.
REQ-041 SHALL be a single module with no sub-module, instantiated beside fifo in the video_in top level.

Verification
REQ-042 SHALL cover one burst: frame_base=32'h1000_0000, frame_start, fifo_burst_ready=1, ack on every cycle -> 16 beats at 0x1000_0000 to 0x1000_003C, cti 010 x15 then 111, and 16 pops.
REQ-043 SHALL cover wait states: ack every third cycle -> addr and data hold between acks, and exactly 16 pops.
REQ-044 SHALL cover frame end: FRAME_WORDS=32 -> two bursts, frame_done pulses once, then return to SYNC, and the next frame restarts at base.
REQ-045 SHALL cover a frame_start during BURST -> frame_miss pulses once, with no effect on addr or word_cnt.
REQ-046 SHALL cover enable dropping at beat 5 -> the burst finishes 16 beats, then IDLE, and cyc=0.
REQ-047 SHALL cover nRST=0 at beat 8 -> cyc, stb and r_ack drop immediately, and after release the state is IDLE with outputs at reset values.
